// File: rtl/rr_arb_lock_if.sv
// Requester/sink-side bundle of the round-robin lock arbiter.
// master is the arbiter view, slave is the requester/sink environment view.
interface rr_arb_lock_if #(
  parameter int unsigned NUM_REQ = 8
);
  localparam int unsigned W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] i_req;
  logic               i_last;
  logic               i_ready;
  logic               o_valid;
  logic [NUM_REQ-1:0] o_grant;
  logic [W-1:0]       o_grant_id;
  logic               o_lock_break;

  modport master (
    input  i_req, i_last, i_ready,
    output o_valid, o_grant, o_grant_id, o_lock_break
  );

  modport slave (
    output i_req, i_last, i_ready,
    input  o_valid, o_grant, o_grant_id, o_lock_break
  );
endinterface

// File: rtl/rr_arb_lock.sv
// Round-robin arbiter with registered grant, multi-beat lock and a beat watchdog
// that forces release of a lock whose final beat never arrives.
module rr_arb_lock #(
  parameter int unsigned NUM_REQ   = 8,
  parameter int unsigned LOCK_EN   = 1,
  parameter int unsigned MAX_BEATS = 0
) (
  input  logic          clk,
  input  logic          rstn,
  rr_arb_lock_if.master bus
);
  localparam int unsigned W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]         state_q, state_d;
  logic               valid_q, valid_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [W-1:0]       grant_id_q, grant_id_d;
  logic               lock_break_q, lock_break_d;
  logic [W-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]      beat_cnt_q, beat_cnt_d;

  logic               accept_c;
  logic               watchdog_c;
  logic               release_c;
  logic [W-1:0]       base_c;
  logic               win_found_c;
  logic [W-1:0]       win_id_c;

  // Beat accounting and release decision for the current grant
  always_comb begin
    accept_c   = (state_q == GRANT) && bus.i_ready;
    watchdog_c = 1'b0;
    if (MAX_BEATS != 0) begin
      watchdog_c = accept_c && !bus.i_last &&
                   (CW'(beat_cnt_q + CW'(1)) == CW'(MAX_BEATS));
    end
    release_c = accept_c && (bus.i_last || (LOCK_EN == 0) || watchdog_c);
    base_c    = release_c ? grant_id_q : ptr_q;
  end

  // Circular first-set scan starting just above the priority base
  always_comb begin
    int unsigned idx;
    win_found_c = 1'b0;
    win_id_c    = '0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(base_c) + k) % NUM_REQ;
      if (!win_found_c && bus.i_req[W'(idx)]) begin
        win_found_c = 1'b1;
        win_id_c    = W'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    ptr_d        = ptr_q;
    beat_cnt_d   = beat_cnt_q;
    lock_break_d = watchdog_c;

    case (state_q)
      IDLE: begin
        if (win_found_c) begin
          state_d    = GRANT;
          valid_d    = 1'b1;
          grant_id_d = win_id_c;
          grant_d    = NUM_REQ'(1) << win_id_c;
        end
      end
      GRANT: begin
        if (release_c) begin
          ptr_d      = grant_id_q;
          beat_cnt_d = '0;
          if (win_found_c) begin
            grant_id_d = win_id_c;
            grant_d    = NUM_REQ'(1) << win_id_c;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            grant_d = '0;
          end
        end else if (accept_c && (MAX_BEATS != 0)) begin
          // Counting only matters for the watchdog; leaving it idle keeps it from wrapping
          beat_cnt_d = CW'(beat_cnt_q + CW'(1));
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      grant_q      <= '0;
      grant_id_q   <= '0;
      lock_break_q <= 1'b0;
      ptr_q        <= W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      lock_break_q <= lock_break_d;
      ptr_q        <= ptr_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_grant      = grant_q;
  assign bus.o_grant_id   = grant_id_q;
  assign bus.o_lock_break = lock_break_q;
endmodule

// File: tb/tb_rr_arb_lock.sv
// Bench for rr_arb_lock: three configurations driven in parallel and compared
// every cycle against a transaction-level round-robin model.
module tb_rr_arb_lock;
  logic clk;
  logic rstn;

  rr_arb_lock_if #(.NUM_REQ(8)) if_a ();
  rr_arb_lock_if #(.NUM_REQ(5)) if_b ();
  rr_arb_lock_if #(.NUM_REQ(8)) if_c ();

  rr_arb_lock #(.NUM_REQ(8), .LOCK_EN(1), .MAX_BEATS(0)) dut_a (.clk(clk), .rstn(rstn), .bus(if_a));
  rr_arb_lock #(.NUM_REQ(5), .LOCK_EN(0), .MAX_BEATS(0)) dut_b (.clk(clk), .rstn(rstn), .bus(if_b));
  rr_arb_lock #(.NUM_REQ(8), .LOCK_EN(1), .MAX_BEATS(4)) dut_c (.clk(clk), .rstn(rstn), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          m_n    [3] = '{8, 5, 8};
  int          m_lock [3] = '{1, 0, 1};
  int          m_mb   [3] = '{0, 0, 4};
  bit          m_busy [3];
  int          m_gid  [3];
  int          m_ptr  [3];
  int          m_beats[3];
  bit          m_lb   [3];

  logic [31:0] r_req  [3];
  logic        r_ready[3];
  logic        r_last [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int scan(input int n, input int start, input logic [31:0] req);
    for (int k = 1; k <= n; k++) begin
      int i;
      i = (start + k) % n;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_busy[d] = 0; m_gid[d] = 0; m_ptr[d] = m_n[d] - 1; m_beats[d] = 0; m_lb[d] = 0;
    end
  endtask

  // Transfer-level view: a grant lives until its releasing beat, then the next one starts
  task automatic model_step(input int d);
    int w;
    bit wd;
    m_lb[d] = 0;
    if (!m_busy[d]) begin
      w = scan(m_n[d], m_ptr[d], r_req[d]);
      if (w >= 0) begin m_busy[d] = 1; m_gid[d] = w; end
    end else if (r_ready[d]) begin
      m_beats[d]++;
      wd = (m_mb[d] != 0) && (m_beats[d] == m_mb[d]) && !r_last[d];
      if (r_last[d] || m_lock[d] == 0 || wd) begin
        m_ptr[d] = m_gid[d]; m_beats[d] = 0; m_lb[d] = wd;
        w = scan(m_n[d], m_ptr[d], r_req[d]);
        if (w >= 0) m_gid[d] = w; else m_busy[d] = 0;
      end
    end
  endtask

  task automatic apply();
    if_a.i_req = 8'(r_req[0]); if_a.i_ready = r_ready[0]; if_a.i_last = r_last[0];
    if_b.i_req = 5'(r_req[1]); if_b.i_ready = r_ready[1]; if_b.i_last = r_last[1];
    if_c.i_req = 8'(r_req[2]); if_c.i_ready = r_ready[2]; if_c.i_last = r_last[2];
  endtask

  task automatic check_model();
    logic        v, lb;
    logic [31:0] g, id, eg;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0:       begin v = if_a.o_valid; g = 32'(if_a.o_grant); id = 32'(if_a.o_grant_id); lb = if_a.o_lock_break; end
        1:       begin v = if_b.o_valid; g = 32'(if_b.o_grant); id = 32'(if_b.o_grant_id); lb = if_b.o_lock_break; end
        default: begin v = if_c.o_valid; g = 32'(if_c.o_grant); id = 32'(if_c.o_grant_id); lb = if_c.o_lock_break; end
      endcase
      eg = m_busy[d] ? (32'd1 << m_gid[d]) : 32'd0;
      chk($sformatf("dut%0d_valid", d), 32'(v), 32'(m_busy[d]));
      chk($sformatf("dut%0d_grant", d), g, eg);
      chk($sformatf("dut%0d_lock_break", d), 32'(lb), 32'(m_lb[d]));
      if (m_busy[d]) chk($sformatf("dut%0d_grant_id", d), id, 32'(m_gid[d]));
    end
  endtask

  // One clock: inputs already set at the falling edge, compare 1 time unit after the rise
  task automatic cyc();
    apply();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic set_in(input int d, input logic [31:0] req, input logic rdy, input logic last);
    r_req[d] = req; r_ready[d] = rdy; r_last[d] = last;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    apply();
    model_reset();
    #1;
    chk("rst_valid", 32'(if_a.o_valid), 32'd0);
    chk("rst_grant", 32'(if_a.o_grant), 32'd0);
    chk("rst_grant_id", 32'(if_a.o_grant_id), 32'd0);
    chk("rst_lock_break", 32'(if_c.o_lock_break), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    for (int d = 0; d < 3; d++) set_in(d, 32'd0, 1'b0, 1'b0);
    apply();
    @(negedge clk);
    do_reset();

    // Single requester streaming with last on every beat
    set_in(0, 32'h01, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t1_grant", 32'(if_a.o_grant), 32'h01);
      chk("t1_id", 32'(if_a.o_grant_id), 32'd0);
    end

    // All requesting: back-to-back rotation with no bubbles
    do_reset();
    set_in(0, 32'hFF, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t2_valid", 32'(if_a.o_valid), 32'd1);
      chk("t2_id", 32'(if_a.o_grant_id), 32'(k % 8));
    end

    // Three-beat locked packet from requester 0, then requester 2
    do_reset();
    set_in(0, 32'h05, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      r_last[0] = (k == 3);
      cyc();
      chk("t3_grant", 32'(if_a.o_grant), (k < 3) ? 32'h01 : 32'h04);
    end

    // Stalled sink freezes grant regardless of request churn
    r_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r_req[0] = 32'($urandom_range(0, 255));
      cyc();
      chk("t4_grant", 32'(if_a.o_grant), 32'h04);
      chk("t4_id", 32'(if_a.o_grant_id), 32'd2);
    end
    set_in(0, 32'h89, 1'b1, 1'b1);
    cyc();
    chk("t4_next_id", 32'(if_a.o_grant_id), 32'd3);
    set_in(0, 32'd0, 1'b0, 1'b0);

    // Non-locking 5-requester arbiter alternates between ids 0 and 4
    do_reset();
    set_in(1, 32'h11, 1'b1, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t5_id", 32'(if_b.o_grant_id), (k % 2 == 1) ? 32'd4 : 32'd0);
    end
    r_req[1] = 32'd0;
    cyc();
    chk("t5_idle_valid", 32'(if_b.o_valid), 32'd0);
    chk("t5_idle_grant", 32'(if_b.o_grant), 32'd0);

    // Runaway lock: watchdog releases after 4 beats and pulses lock_break once
    do_reset();
    set_in(2, 32'h03, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("t6_id", 32'(if_c.o_grant_id), (k < 4) ? 32'd0 : 32'd1);
      chk("t6_lock_break", 32'(if_c.o_lock_break), (k == 4) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset while granted clears outputs without a clock edge
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_valid", 32'(if_c.o_valid), 32'd0);
    chk("t6_async_grant", 32'(if_c.o_grant), 32'd0);
    chk("t6_async_id", 32'(if_c.o_grant_id), 32'd0);
    chk("t6_async_lb", 32'(if_c.o_lock_break), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;

    // Random traffic on all three configurations
    for (int k = 0; k < 600; k++) begin
      for (int d = 0; d < 3; d++) begin
        r_req[d]   = 32'($urandom) & ((32'd1 << m_n[d]) - 32'd1);
        if ($urandom_range(0, 3) == 0) r_req[d] = 32'd0;
        r_ready[d] = ($urandom_range(0, 3) != 0);
        r_last[d]  = ($urandom_range(0, 3) == 0);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
